board_rx_ctrl: RTL



---
 rtl/fgbitw_pkg.sv | 32 +++
 rtl/board_rx_ctrl_if.sv | 24 ++
 rtl/board_rx_ctrl_pkt_checker.sv | 23 ++
 rtl/board_rx_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fgbitw_pkg.sv
// fgbitw_pkg: shared types and constants for the board receive path.
//   board_rx_state_t : sequencer states of board_rx_ctrl
//   PKT_BITS         : width of one board word (81 cells x 2 bits)
//   has_illegal_cell : screens a board word for the reserved cell code
package fgbitw_pkg;

  localparam int PKT_BITS  = 162;
  localparam int CELL_BITS = 2;
  localparam int N_CELLS   = 81;
  localparam logic [CELL_BITS-1:0] CELL_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    RST_RX  = 3'd0,
    IDLE    = 3'd1,
    RX      = 3'd2,
    TIMEOUT = 3'd3,
    CHECK   = 3'd4,
    PUBLISH = 3'd5,
    SKIP    = 3'd6
  } board_rx_state_t;

  // True when any cell of the word carries the reserved code.
  function automatic logic has_illegal_cell(input logic [PKT_BITS-1:0] pkt);
    logic found;
    found = 1'b0;
    for (int i = 0; i < N_CELLS; i++) begin
      found = found | (pkt[i*CELL_BITS +: CELL_BITS] == CELL_ILLEGAL);
    end
    return found;
  endfunction

endpackage

// File: rtl/board_rx_ctrl_if.sv
// board_rx_ctrl_if: receiver-side and consumer-side signals of board_rx_ctrl.
//   rx_ready_in / rx_data_in / rx_rst_out : UART packet receiver link
//   brd_valid_out / brd_ready_in / brd_data_out : board handshake to the game logic
// slave  = the controller, master = the surrounding environment.
interface board_rx_ctrl_if;
  import fgbitw_pkg::*;

  logic                rx_ready_in;
  logic [PKT_BITS-1:0] rx_data_in;
  logic                rx_rst_out;
  logic                brd_valid_out;
  logic                brd_ready_in;
  logic [PKT_BITS-1:0] brd_data_out;

  modport master (
    output rx_ready_in, rx_data_in, brd_ready_in,
    input  rx_rst_out, brd_valid_out, brd_data_out
  );

  modport slave (
    input  rx_ready_in, rx_data_in, brd_ready_in,
    output rx_rst_out, brd_valid_out, brd_data_out
  );
endinterface

// File: rtl/board_rx_ctrl_pkt_checker.sv
// pkt_checker: combinational screening of a captured board word.
//   pkt               : word just captured from the receiver
//   last              : previously received legal word
//   published         : word currently shown to the consumer
//   illegal           : pkt contains at least one reserved cell code
//   same_as_last      : pkt == last
//   same_as_published : pkt == published
module pkt_checker
  import fgbitw_pkg::*;
(
  input  logic [PKT_BITS-1:0] pkt,
  input  logic [PKT_BITS-1:0] last,
  input  logic [PKT_BITS-1:0] published,
  output logic                illegal,
  output logic                same_as_last,
  output logic                same_as_published
);

  assign illegal           = has_illegal_cell(pkt);
  assign same_as_last      = (pkt == last);
  assign same_as_published = (pkt == published);

endmodule

// File: rtl/board_rx_ctrl.sv
// board_rx_ctrl: sequencer between the UART packet receiver and the game logic
// (system clock nominally 65 MHz). Resets and supervises the receiver, times
// out stalled packets, screens and debounces board words, and publishes a
// stable board over a valid/ready handshake.
//   clk_in, rst_n_in : clock and asynchronous active-low reset
//   bus              : receiver link and consumer handshake (slave side)
//   err_timeout_out  : one-cycle pulse when a packet stalls in reception
//   err_illegal_out  : one-cycle pulse when a packet holds a reserved cell code
//   drop_cnt_out     : dropped packets, saturating at 255
module board_rx_ctrl
  import fgbitw_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int RX_RST_CYC  = 4,
  parameter int STABLE_CNT  = 2
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  board_rx_ctrl_if.slave   bus,
  output logic             err_timeout_out,
  output logic             err_illegal_out,
  output logic [7:0]       drop_cnt_out
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int RST_W = $clog2(RX_RST_CYC + 1);

  localparam logic [2:0] ST_RST_RX  = RST_RX;
  localparam logic [2:0] ST_IDLE    = IDLE;
  localparam logic [2:0] ST_RX      = RX;
  localparam logic [2:0] ST_TIMEOUT = TIMEOUT;
  localparam logic [2:0] ST_CHECK   = CHECK;
  localparam logic [2:0] ST_PUBLISH = PUBLISH;
  localparam logic [2:0] ST_SKIP    = SKIP;

  logic [2:0]          state_r, state_nxt_s;
  logic [TMR_W-1:0]    timer_r;
  logic [RST_W-1:0]    rst_cnt_r;
  logic                rx_ready_d_r;
  logic [PKT_BITS-1:0] pkt_q_r, last_q_r, brd_data_r;
  logic [3:0]          match_cnt_r, match_nxt_s;
  logic                published_r, brd_valid_r, rx_rst_r;
  logic                err_timeout_r, err_illegal_r;
  logic [7:0]          drop_cnt_r;

  logic rx_fall_s, rx_rise_s;
  logic illegal_s, same_last_s, same_pub_s;
  logic capture_s, last_load_s, publish_s, handshake_s;
  logic drop_inc_s, tmo_s, ill_s;

  assign rx_fall_s = rx_ready_d_r & ~bus.rx_ready_in;
  assign rx_rise_s = ~rx_ready_d_r & bus.rx_ready_in;

  pkt_checker u_pkt_checker (
    .pkt               (pkt_q_r),
    .last              (last_q_r),
    .published         (brd_data_r),
    .illegal           (illegal_s),
    .same_as_last      (same_last_s),
    .same_as_published (same_pub_s)
  );

  // Next-state and per-cycle action strobes of the sequencer.
  always_comb begin
    state_nxt_s = state_r;
    match_nxt_s = match_cnt_r;
    capture_s   = 1'b0;
    last_load_s = 1'b0;
    publish_s   = 1'b0;
    handshake_s = 1'b0;
    drop_inc_s  = 1'b0;
    tmo_s       = 1'b0;
    ill_s       = 1'b0;
    case (state_r)
      ST_RST_RX: begin
        if (rst_cnt_r == RST_W'(RX_RST_CYC - 1)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RST_RX;
        end
      end
      ST_IDLE: begin
        if (rx_fall_s) begin
          state_nxt_s = ST_RX;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RX: begin
        // Completion is tested first so it wins over an expiring timer.
        if (rx_rise_s) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_CHECK;
        end else if (timer_r == TMR_W'(TIMEOUT_CYC - 1)) begin
          tmo_s       = 1'b1;
          drop_inc_s  = 1'b1;
          match_nxt_s = 4'd0;
          state_nxt_s = ST_TIMEOUT;
        end else begin
          state_nxt_s = ST_RX;
        end
      end
      ST_TIMEOUT: begin
        state_nxt_s = ST_RST_RX;
      end
      ST_CHECK: begin
        if (illegal_s) begin
          ill_s       = 1'b1;
          drop_inc_s  = 1'b1;
          match_nxt_s = 4'd0;
          state_nxt_s = ST_IDLE;
        end else begin
          if (same_last_s) begin
            match_nxt_s = (match_cnt_r == 4'd15) ? 4'd15 : match_cnt_r + 4'd1;
          end else begin
            last_load_s = 1'b1;
            match_nxt_s = 4'd1;
          end
          // Republishing an unchanged board is suppressed, except for the
          // very first board after reset (brd_data_r is then only a reset value).
          if ((match_nxt_s >= 4'(STABLE_CNT)) && (!same_pub_s || !published_r)) begin
            publish_s   = 1'b1;
            state_nxt_s = ST_PUBLISH;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
      end
      ST_PUBLISH: begin
        // A packet completing while the board is held is lost; count it here.
        if (rx_rise_s) begin
          drop_inc_s = 1'b1;
        end else begin
          drop_inc_s = 1'b0;
        end
        if (brd_valid_r && bus.brd_ready_in) begin
          handshake_s = 1'b1;
          if (bus.rx_ready_in) begin
            state_nxt_s = ST_IDLE;
          end else begin
            // A packet is already in flight; it is counted now and ignored in SKIP.
            drop_inc_s  = 1'b1;
            state_nxt_s = ST_SKIP;
          end
        end else begin
          state_nxt_s = ST_PUBLISH;
        end
      end
      ST_SKIP: begin
        if (bus.rx_ready_in) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SKIP;
        end
      end
      default: begin
        state_nxt_s = ST_RST_RX;
      end
    endcase
  end

  // Sequencer state, counters, captured words and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r       <= ST_RST_RX;
      timer_r       <= '0;
      rst_cnt_r     <= '0;
      rx_ready_d_r  <= 1'b1;
      pkt_q_r       <= '0;
      last_q_r      <= '0;
      brd_data_r    <= '0;
      match_cnt_r   <= 4'd0;
      published_r   <= 1'b0;
      brd_valid_r   <= 1'b0;
      rx_rst_r      <= 1'b1;
      err_timeout_r <= 1'b0;
      err_illegal_r <= 1'b0;
      drop_cnt_r    <= 8'd0;
    end else begin
      state_r       <= state_nxt_s;
      rx_ready_d_r  <= bus.rx_ready_in;
      match_cnt_r   <= match_nxt_s;
      rx_rst_r      <= (state_nxt_s == ST_RST_RX);
      err_timeout_r <= tmo_s;
      err_illegal_r <= ill_s;
      timer_r       <= (state_r == ST_RX) ? timer_r + TMR_W'(1) : '0;
      rst_cnt_r     <= (state_r == ST_RST_RX) ? rst_cnt_r + RST_W'(1) : '0;
      if (capture_s) begin
        pkt_q_r <= bus.rx_data_in;
      end
      if (last_load_s) begin
        last_q_r <= pkt_q_r;
      end
      if (publish_s) begin
        brd_data_r  <= pkt_q_r;
        published_r <= 1'b1;
        brd_valid_r <= 1'b1;
      end else if (handshake_s) begin
        brd_valid_r <= 1'b0;
      end
      if (drop_inc_s && (drop_cnt_r != 8'd255)) begin
        drop_cnt_r <= drop_cnt_r + 8'd1;
      end
    end
  end

  assign bus.rx_rst_out    = rx_rst_r;
  assign bus.brd_valid_out = brd_valid_r;
  assign bus.brd_data_out  = brd_data_r;
  assign err_timeout_out   = err_timeout_r;
  assign err_illegal_out   = err_illegal_r;
  assign drop_cnt_out      = drop_cnt_r;

endmodule
